// File: rtl/mips_core_pkg.sv
// Shared rename/issue constants and helpers for the MIPS OoO core.
package mips_core_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int RETIRE_W  = 8;

  typedef logic [PREG_W-1:0]    preg_t;
  typedef logic [NUM_PREGS-1:0] preg_mask_t;
  typedef logic [PREG_W:0]      preg_cnt_t;

  // Pregs 0..NUM_AREGS-1 hold architectural state out of reset; the rest are free.
  localparam preg_mask_t RESET_FREE_MASK = preg_mask_t'({NUM_PREGS{1'b1}} << NUM_AREGS);

  // Number of set bits in a preg mask.
  function automatic preg_cnt_t popcount(input preg_mask_t v);
    preg_cnt_t cnt;
    cnt = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      cnt = cnt + preg_cnt_t'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pri_enc_lsb.sv
// Lowest-set-bit priority encoder with an any-bit-set flag. Purely combinational.
module pri_enc_lsb #(
  parameter int N = 64,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  // Scan from the top down so the last hit written is the lowest index.
  always_comb begin
    // NOTE: outputs get a default before the loop so no latch is inferred.
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Physical-register free list and operand-ready table for rename/issue.
// Preg 0 is the hardwired $zero: never allocated, never released, always ready.
module phys_reg_free_list
  import mips_core_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_req,
  output logic                       alloc_grant,
  output logic [PREG_W-1:0]          alloc_preg,
  output logic                       alloc_valid,
  input  logic                       wb_valid,
  input  logic [PREG_W-1:0]          wb_preg,
  input  logic [RETIRE_W-1:0]        retire_valid,
  input  logic [RETIRE_W*PREG_W-1:0] retire_preg,
  input  logic                       flush,
  input  logic [NUM_PREGS-1:0]       flush_release,
  output logic [NUM_PREGS-1:0]       ready_list,
  output logic [PREG_W:0]            free_count,
  output logic                       pool_empty
);

  preg_mask_t free_mask, free_d;
  preg_mask_t ready_q, ready_d;
  preg_mask_t release_mask;
  preg_cnt_t  count_q, count_d;
  logic       empty_q;
  preg_t      enc_idx;
  logic       enc_any;

  pri_enc_lsb #(.N(NUM_PREGS)) u_enc (
    .vec (free_mask),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Zero-cycle grant from the current free mask; pregs released this cycle
  // are not in free_mask yet, so they cannot be handed out until next cycle.
  assign alloc_valid = enc_any;
  assign alloc_preg  = enc_any ? enc_idx : '0;
  assign alloc_grant = rst_n & alloc_req & enc_any & ~flush;

  // Next-state for the free and ready masks.
  always_comb begin
    release_mask = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      if (retire_valid[i]) release_mask[retire_preg[i*PREG_W +: PREG_W]] = 1'b1;
    end
    if (flush) release_mask = release_mask | flush_release;
    release_mask[0] = 1'b0;

    // Releases are OR-ed in first, so freeing an already-free preg is a no-op.
    free_d  = free_mask | release_mask;
    ready_d = ready_q | (flush ? flush_release : '0);
    if (wb_valid) ready_d[wb_preg] = 1'b1;
    // Allocation clears last: it wins over a same-cycle writeback on ready.
    if (alloc_grant) begin
      free_d[alloc_preg]  = 1'b0;
      ready_d[alloc_preg] = 1'b0;
    end
    free_d[0]  = 1'b0;
    ready_d[0] = 1'b1;

    // Count is recomputed from the next mask, so it can never drift.
    count_d = popcount(free_d);
  end

  // State registers, all asynchronously reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_mask <= RESET_FREE_MASK;
      ready_q   <= '1;
      count_q   <= preg_cnt_t'(NUM_PREGS - NUM_AREGS);
      empty_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values.
      free_mask <= free_d;
      ready_q   <= ready_d;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
    end
  end

  assign ready_list = ready_q;
  assign free_count = count_q;
  assign pool_empty = empty_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Self-checking bench for phys_reg_free_list: directed scenarios plus a
// randomized run against a per-preg array model of the allocator.
module tb_phys_reg_free_list;
  import mips_core_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       alloc_req;
  logic                       alloc_grant;
  logic [PREG_W-1:0]          alloc_preg;
  logic                       alloc_valid;
  logic                       wb_valid;
  logic [PREG_W-1:0]          wb_preg;
  logic [RETIRE_W-1:0]        retire_valid;
  logic [RETIRE_W*PREG_W-1:0] retire_preg;
  logic                       flush;
  logic [NUM_PREGS-1:0]       flush_release;
  logic [NUM_PREGS-1:0]       ready_list;
  logic [PREG_W:0]            free_count;
  logic                       pool_empty;

  int total = 0;
  int bad   = 0;

  bit m_free  [NUM_PREGS];
  bit m_ready [NUM_PREGS];

  phys_reg_free_list dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_req     (alloc_req),
    .alloc_grant   (alloc_grant),
    .alloc_preg    (alloc_preg),
    .alloc_valid   (alloc_valid),
    .wb_valid      (wb_valid),
    .wb_preg       (wb_preg),
    .retire_valid  (retire_valid),
    .retire_preg   (retire_preg),
    .flush         (flush),
    .flush_release (flush_release),
    .ready_list    (ready_list),
    .free_count    (free_count),
    .pool_empty    (pool_empty)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < NUM_PREGS; i++) begin
      m_free[i]  = (i >= NUM_AREGS);
      m_ready[i] = 1'b1;
    end
  endfunction

  function automatic int model_lowest();
    for (int i = 0; i < NUM_PREGS; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NUM_PREGS; i++) n += int'(m_free[i]);
    return n;
  endfunction

  function automatic logic [NUM_PREGS-1:0] model_ready_vec();
    logic [NUM_PREGS-1:0] v;
    for (int i = 0; i < NUM_PREGS; i++) v[i] = m_ready[i];
    return v;
  endfunction

  function automatic bit model_grant();
    return rst_n && alloc_req && (model_lowest() >= 0) && !flush;
  endfunction

  task automatic idle_inputs();
    alloc_req     = 1'b0;
    wb_valid      = 1'b0;
    wb_preg       = '0;
    retire_valid  = '0;
    retire_preg   = '0;
    flush         = 1'b0;
    flush_release = '0;
  endtask

  // One clock: model computes next state from current inputs, then both advance.
  task automatic tick();
    int lo;
    bit g;
    bit nf [NUM_PREGS];
    bit nr [NUM_PREGS];
    lo = model_lowest();
    g  = model_grant();
    nf = m_free;
    nr = m_ready;
    for (int p = 0; p < RETIRE_W; p++) begin
      if (retire_valid[p]) begin
        int r;
        r = int'(retire_preg[p*PREG_W +: PREG_W]);
        if (r != 0) nf[r] = 1'b1;
      end
    end
    if (flush) begin
      for (int i = 1; i < NUM_PREGS; i++) begin
        if (flush_release[i]) begin
          nf[i] = 1'b1;
          nr[i] = 1'b1;
        end
      end
    end
    if (wb_valid) nr[int'(wb_preg)] = 1'b1;
    if (g) begin
      nf[lo] = 1'b0;
      nr[lo] = 1'b0;
    end
    @(posedge clk);
    m_free  = nf;
    m_ready = nr;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    rst_n     = 1'b0;
    alloc_req = 1'b1;
    #12;
    total++; if (alloc_grant !== 1'b0) begin bad++; $display("FAIL rst_grant got=%0b exp=0", alloc_grant); end
    total++; if (free_count !== 7'd32) begin bad++; $display("FAIL rst_count got=%0d exp=32", free_count); end
    total++; if (ready_list !== {NUM_PREGS{1'b1}}) begin bad++; $display("FAIL rst_ready got=%h exp=all ones", ready_list); end
    total++; if (alloc_preg !== 6'd32) begin bad++; $display("FAIL rst_alloc_preg got=%0d exp=32", alloc_preg); end
    total++; if (alloc_valid !== 1'b1) begin bad++; $display("FAIL rst_alloc_valid got=%0b exp=1", alloc_valid); end
    total++; if (pool_empty !== 1'b0) begin bad++; $display("FAIL rst_empty got=%0b exp=0", pool_empty); end
    alloc_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    total++; if (free_count !== 7'd32) begin bad++; $display("FAIL idle_count got=%0d exp=32", free_count); end
  endtask

  task automatic test_alloc_wb();
    for (int k = 0; k < 3; k++) begin
      alloc_req = 1'b1;
      #1;
      total++; if (alloc_grant !== 1'b1) begin bad++; $display("FAIL alloc_grant_%0d got=%0b exp=1", k, alloc_grant); end
      total++; if (alloc_preg !== PREG_W'(32 + k)) begin bad++; $display("FAIL alloc_preg_%0d got=%0d exp=%0d", k, alloc_preg, 32 + k); end
      tick();
    end
    alloc_req = 1'b0;
    total++; if (free_count !== 7'd29) begin bad++; $display("FAIL alloc_count got=%0d exp=29", free_count); end
    total++; if (ready_list[34:32] !== 3'b000) begin bad++; $display("FAIL alloc_notready got=%b exp=000", ready_list[34:32]); end
    wb_valid = 1'b1;
    wb_preg  = 6'd33;
    #1;
    total++; if (ready_list[33] !== 1'b0) begin bad++; $display("FAIL wb_bypass got=%0b exp=0", ready_list[33]); end
    tick();
    wb_valid = 1'b0;
    total++; if (ready_list[34:32] !== 3'b010) begin bad++; $display("FAIL wb_ready got=%b exp=010", ready_list[34:32]); end
  endtask

  task automatic test_exhaust();
    alloc_req = 1'b1;
    for (int k = 0; k < 29; k++) begin
      #1;
      total++; if (alloc_preg !== PREG_W'(model_lowest())) begin bad++; $display("FAIL drain_preg_%0d got=%0d exp=%0d", k, alloc_preg, model_lowest()); end
      tick();
    end
    #1;
    total++; if (pool_empty !== 1'b1) begin bad++; $display("FAIL empty_flag got=%0b exp=1", pool_empty); end
    total++; if (free_count !== 7'd0) begin bad++; $display("FAIL empty_count got=%0d exp=0", free_count); end
    total++; if (alloc_grant !== 1'b0) begin bad++; $display("FAIL empty_grant got=%0b exp=0", alloc_grant); end
    total++; if (alloc_valid !== 1'b0) begin bad++; $display("FAIL empty_valid got=%0b exp=0", alloc_valid); end
    total++; if (alloc_preg !== 6'd0) begin bad++; $display("FAIL empty_preg got=%0d exp=0", alloc_preg); end
    retire_valid = 8'h20;
    retire_preg[5*PREG_W +: PREG_W] = 6'd40;
    #1;
    total++; if (alloc_grant !== 1'b0) begin bad++; $display("FAIL same_cycle_free got=%0b exp=0", alloc_grant); end
    tick();
    retire_valid = '0;
    retire_preg  = '0;
    #1;
    total++; if (alloc_grant !== 1'b1) begin bad++; $display("FAIL refill_grant got=%0b exp=1", alloc_grant); end
    total++; if (alloc_preg !== 6'd40) begin bad++; $display("FAIL refill_preg got=%0d exp=40", alloc_preg); end
    tick();
    alloc_req = 1'b0;
    total++; if (pool_empty !== 1'b1) begin bad++; $display("FAIL reempty got=%0b exp=1", pool_empty); end
  endtask

  task automatic test_retire_dup();
    retire_valid = 8'h02;
    retire_preg[1*PREG_W +: PREG_W] = 6'd50;
    tick();
    retire_preg  = '0;
    alloc_req    = 1'b1;
    retire_valid = 8'b0000_1001;
    retire_preg[0*PREG_W +: PREG_W] = 6'd7;
    retire_preg[3*PREG_W +: PREG_W] = 6'd7;
    #1;
    total++; if (alloc_preg !== 6'd50 || alloc_grant !== 1'b1) begin bad++; $display("FAIL dup_grant got=%0d/%0b exp=50/1", alloc_preg, alloc_grant); end
    tick();
    retire_valid = '0;
    retire_preg  = '0;
    total++; if (free_count !== 7'd1) begin bad++; $display("FAIL dup_count got=%0d exp=1", free_count); end
    #1;
    total++; if (alloc_preg !== 6'd7) begin bad++; $display("FAIL dup_next got=%0d exp=7", alloc_preg); end
    tick();
    alloc_req = 1'b0;
    total++; if (free_count !== 7'd0) begin bad++; $display("FAIL dup_once got=%0d exp=0", free_count); end
  endtask

  task automatic test_flush();
    alloc_req     = 1'b1;
    flush         = 1'b1;
    flush_release = '0;
    flush_release[33] = 1'b1;
    flush_release[34] = 1'b1;
    flush_release[0]  = 1'b1;
    #1;
    total++; if (alloc_grant !== 1'b0) begin bad++; $display("FAIL flush_grant got=%0b exp=0", alloc_grant); end
    tick();
    flush = 1'b0;
    flush_release = '0;
    alloc_req = 1'b0;
    #1;
    total++; if (free_count !== 7'd2) begin bad++; $display("FAIL flush_count got=%0d exp=2", free_count); end
    total++; if (ready_list[34:33] !== 2'b11 || ready_list[0] !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b/%b exp=11/1", ready_list[34:33], ready_list[0]); end
    total++; if (alloc_preg !== 6'd33) begin bad++; $display("FAIL flush_lowest got=%0d exp=33", alloc_preg); end
    retire_valid = 8'h01;
    retire_preg[0*PREG_W +: PREG_W] = 6'd33;
    tick();
    retire_valid = '0;
    retire_preg  = '0;
    total++; if (free_count !== 7'd2) begin bad++; $display("FAIL double_free got=%0d exp=2", free_count); end
  endtask

  task automatic test_full_pool();
    for (int pass = 0; pass < 2; pass++) begin
      for (int base = 0; base < NUM_PREGS; base += RETIRE_W) begin
        retire_valid = '1;
        for (int p = 0; p < RETIRE_W; p++) retire_preg[p*PREG_W +: PREG_W] = PREG_W'(base + p);
        tick();
      end
      retire_valid = '0;
      retire_preg  = '0;
      total++; if (free_count !== 7'd63) begin bad++; $display("FAIL full_count_%0d got=%0d exp=63", pass, free_count); end
    end
    #1;
    total++; if (alloc_preg !== 6'd1) begin bad++; $display("FAIL full_lowest got=%0d exp=1", alloc_preg); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      int lo;
      alloc_req     = ($urandom_range(0, 1) == 1);
      wb_valid      = ($urandom_range(0, 1) == 1);
      wb_preg       = PREG_W'($urandom_range(0, NUM_PREGS - 1));
      retire_valid  = RETIRE_W'($urandom()) & RETIRE_W'($urandom()) & RETIRE_W'($urandom());
      retire_preg   = (RETIRE_W*PREG_W)'({$urandom(), $urandom()});
      flush         = ($urandom_range(0, 15) == 0);
      flush_release = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
      #1;
      lo = model_lowest();
      total++; if (alloc_valid !== (lo >= 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, alloc_valid, lo >= 0); end
      total++; if (alloc_preg !== PREG_W'((lo >= 0) ? lo : 0)) begin bad++; $display("FAIL rnd_preg c=%0d got=%0d exp=%0d", c, alloc_preg, lo); end
      total++; if (alloc_grant !== model_grant()) begin bad++; $display("FAIL rnd_grant c=%0d got=%0b exp=%0b", c, alloc_grant, model_grant()); end
      tick();
      total++; if (free_count !== (PREG_W+1)'(model_count())) begin bad++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, free_count, model_count()); end
      total++; if (pool_empty !== (model_count() == 0)) begin bad++; $display("FAIL rnd_empty c=%0d got=%0b exp=%0b", c, pool_empty, model_count() == 0); end
      total++; if (ready_list !== model_ready_vec()) begin bad++; $display("FAIL rnd_ready c=%0d got=%h exp=%h", c, ready_list, model_ready_vec()); end
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    alloc_req = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (free_count !== 7'd32) begin bad++; $display("FAIL arst_count got=%0d exp=32", free_count); end
    total++; if (ready_list !== model_ready_vec()) begin bad++; $display("FAIL arst_ready got=%h exp=%h", ready_list, model_ready_vec()); end
    total++; if (alloc_preg !== 6'd32 || alloc_valid !== 1'b1) begin bad++; $display("FAIL arst_alloc got=%0d/%0b exp=32/1", alloc_preg, alloc_valid); end
    total++; if (pool_empty !== 1'b0 || alloc_grant !== 1'b0) begin bad++; $display("FAIL arst_flags got=%0b/%0b exp=0/0", pool_empty, alloc_grant); end
    alloc_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (free_count !== 7'd32) begin bad++; $display("FAIL arst_hold got=%0d exp=32", free_count); end
  endtask

  initial begin
    test_reset();
    test_alloc_wb();
    test_exhaust();
    test_retire_dup();
    test_flush();
    test_full_pool();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
